// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sequencer: opcode and error encodings,
// controller state type and the result bundle.
package alu_pkg;

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_MUL = 4'd3;
  localparam logic [3:0] OP_DIV = 4'd4;
  localparam logic [3:0] OP_MOD = 4'd5;
  localparam logic [3:0] OP_AND = 4'd9;

  localparam logic [1:0] ERR_OK    = 2'b00;
  localparam logic [1:0] ERR_DIV0  = 2'b01;
  localparam logic [1:0] ERR_BADOP = 2'b10;
  localparam logic [1:0] ERR_CARRY = 2'b11;

  typedef enum logic [1:0] {IDLE, EXEC, DIV, RESP} ctl_state_t;

  typedef struct packed {
    logic [7:0] c;
    logic [1:0] err;
  } alu_result_t;

  function automatic logic is_div_op(input logic [3:0] op);
    return (op == OP_DIV) || (op == OP_MOD);
  endfunction

endpackage

// File: rtl/div_step.sv
// One iteration of a 4-bit restoring divider: shift in the next dividend bit
// and keep the trial subtraction only when it does not go negative.
module div_step (
  input  logic [3:0] rem,
  input  logic       a_bit,
  input  logic [3:0] divisor,
  output logic [3:0] rem_next,
  output logic       q_bit
);

  logic [4:0] shifted;
  logic [3:0] trial;

  assign shifted  = {rem, a_bit};
  // rem < divisor on entry, so the true difference always fits in 4 bits.
  assign trial    = shifted[3:0] - divisor;
  assign q_bit    = (shifted >= {1'b0, divisor});
  assign rem_next = q_bit ? trial : shifted[3:0];

endmodule

// File: rtl/alu_op_controller.sv
// Request/response sequencer for the 4-bit ALU: single-cycle ops execute in
// one cycle, DIV/MOD run four restoring steps before the response is held.
module alu_op_controller
  import alu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [3:0] req_a,
  input  logic [3:0] req_b,
  input  logic [3:0] req_opcode,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_c,
  output logic [1:0] rsp_error,
  output logic       busy,
  output logic [7:0] op_count
);

  ctl_state_t  state_reg, state_next;
  logic [3:0]  a_reg, b_reg, op_reg;
  logic [3:0]  rem_reg;
  logic [2:0]  quot_reg;  // first three quotient bits; the fourth comes from the last step
  logic [1:0]  iter_reg;
  logic [7:0]  rsp_c_reg;
  logic [1:0]  rsp_error_reg;
  logic [7:0]  op_count_reg;

  logic [4:0]  sum5, diff5;
  logic [7:0]  prod;
  alu_result_t exec_res;
  logic [3:0]  rem_new;
  logic        q_bit;
  logic [7:0]  div_c;

  div_step u_div_step (
    .rem      (rem_reg),
    .a_bit    (a_reg[2'd3 - iter_reg]),
    .divisor  (b_reg),
    .rem_next (rem_new),
    .q_bit    (q_bit)
  );

  assign div_c = (op_reg == OP_MOD) ? {4'b0, rem_new} : {4'b0, quot_reg, q_bit};

  always_comb begin
    sum5         = {1'b0, a_reg} + {1'b0, b_reg};
    diff5        = {1'b0, a_reg} - {1'b0, b_reg};
    prod         = {4'b0, a_reg} * {4'b0, b_reg};
    exec_res.c   = 8'h00;
    exec_res.err = ERR_BADOP;
    case (op_reg)
      OP_NOP: exec_res.err = ERR_OK;
      OP_ADD: begin
        exec_res.c   = {4'b0, sum5[3:0]};
        exec_res.err = sum5[4] ? ERR_CARRY : ERR_OK;
      end
      OP_SUB: begin
        exec_res.c   = {4'b0, diff5[3:0]};
        exec_res.err = diff5[4] ? ERR_CARRY : ERR_OK;
      end
      OP_MUL: begin
        exec_res.c   = prod;
        exec_res.err = ERR_OK;
      end
      OP_DIV, OP_MOD: exec_res.err = (b_reg == 4'd0) ? ERR_DIV0 : ERR_OK;
      OP_AND: begin
        exec_res.c   = {4'b0, a_reg & b_reg};
        exec_res.err = ERR_OK;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) state_reg <= IDLE;
    else      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (req_valid) state_next = EXEC;
      EXEC: state_next = (is_div_op(op_reg) && b_reg != 4'd0) ? DIV : RESP;
      DIV:  if (iter_reg == 2'd3) state_next = RESP;
      RESP: if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    busy      = 1'b1;
    case (state_reg)
      IDLE: begin
        req_ready = rst;
        busy      = 1'b0;
      end
      RESP:    rsp_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      a_reg         <= 4'd0;
      b_reg         <= 4'd0;
      op_reg        <= 4'd0;
      rem_reg       <= 4'd0;
      quot_reg      <= 3'd0;
      iter_reg      <= 2'd0;
      rsp_c_reg     <= 8'h00;
      rsp_error_reg <= ERR_OK;
      op_count_reg  <= 8'd0;
    end else begin
      case (state_reg)
        IDLE: if (req_valid) begin
          a_reg  <= req_a;
          b_reg  <= req_b;
          op_reg <= req_opcode;
        end
        EXEC: if (is_div_op(op_reg) && b_reg != 4'd0) begin
          rem_reg  <= 4'd0;
          quot_reg <= 3'd0;
          iter_reg <= 2'd0;
        end else begin
          rsp_c_reg     <= exec_res.c;
          rsp_error_reg <= exec_res.err;
        end
        DIV: begin
          rem_reg  <= rem_new;
          quot_reg <= {quot_reg[1:0], q_bit};
          iter_reg <= iter_reg + 2'd1;
          if (iter_reg == 2'd3) begin
            rsp_c_reg     <= div_c;
            rsp_error_reg <= ERR_OK;
          end
        end
        RESP: if (rsp_ready) op_count_reg <= op_count_reg + 8'd1;
        default: ;
      endcase
    end
  end

  assign rsp_c     = rsp_c_reg;
  assign rsp_error = rsp_error_reg;
  assign op_count  = op_count_reg;

endmodule
